// File: rtl/bram_port_arbiter_pkg.sv
// bram_arb_pkg: shared types and helpers for bram_port_arbiter.
package bram_arb_pkg;

    localparam int LAT_NOREG = 1;
    localparam int LAT_REG   = 2;
    localparam int ID_MAX_W  = 3;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Sized for the largest supported requester count; the top slices it down.
    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } rd_track_t;

endpackage

// File: rtl/bram_port_arbiter_pick.sv
// bram_arb_pick: combinational priority picker searching upward from a start index with wrap.
module bram_arb_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          hit
);

    int j;

    // Walk from lowest priority to highest so the nearest requester overwrites.
    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IW'(j);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port among NUM_REQ requesters and tags read responses.
// Define BRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NB_COL       = 4,
    parameter int COL_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0]                     req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
    input  logic [NUM_REQ*NB_COL*COL_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*NB_COL-1:0]              req_be,
    output logic                                   rsp_valid,
    output logic [clog2_min1(NUM_REQ)-1:0]         rsp_id,
    output logic [NB_COL*COL_WIDTH-1:0]            rsp_rdata,
    output logic                                   bram_en,
    output logic [NB_COL-1:0]                      bram_we,
    output logic [ADDR_WIDTH-1:0]                  bram_addr,
    output logic [NB_COL*COL_WIDTH-1:0]            bram_din,
    output logic                                   bram_regce,
    input  logic [NB_COL*COL_WIDTH-1:0]            bram_dout
);

    localparam int DW  = NB_COL * COL_WIDTH;
    localparam int IDW = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     idx;
    logic [IDW-1:0]     ptr;
    logic               hit;
    logic               take;
    logic               wr;
    rd_track_t [READ_LATENCY-1:0] trk_d;
    rd_track_t [READ_LATENCY-1:0] trk_q;

    bram_arb_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
        .req   (req_valid),
        .start (ptr),
        .gnt   (gnt),
        .idx   (idx),
        .hit   (hit)
    );

`ifdef BRAM_ARB_RR_EN
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] ptr_q;

    always_comb ptr_d = !take ? ptr_q : (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        take      = hit & ~rst;
        wr        = take & req_we[idx];
        req_ready = take ? gnt : '0;
        bram_en   = take;
        bram_addr = take ? req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        bram_we   = wr ? req_be[idx*NB_COL +: NB_COL] : '0;
        bram_din  = wr ? req_wdata[idx*DW +: DW] : '0;
        trk_d[0].valid = take & ~req_we[idx];
        trk_d[0].id    = ID_MAX_W'(idx);
        for (int s = 1; s < READ_LATENCY; s++) trk_d[s] = trk_q[s-1];
    end

    // Clearing the tracker on reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst)
        if (rst) trk_q <= '0;
        else     trk_q <= trk_d;

    assign rsp_valid  = trk_q[READ_LATENCY-1].valid;
    assign rsp_id     = trk_q[READ_LATENCY-1].id[IDW-1:0];
    assign rsp_rdata  = rsp_valid ? bram_dout : '0;
    assign bram_regce = ~rst & ((READ_LATENCY == LAT_NOREG) | trk_q[0].valid);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed bench for bram_port_arbiter at READ_LATENCY 2 and 1, with behavioural RAMs.
// Expectations follow BRAM_ARB_RR_EN when the bench is built with it.
module tb_bram_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid;
    logic [3:0]   req_we;
    logic [35:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_be;

    logic [3:0]  ready_a, ready_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [1:0]  rsp_id_a, rsp_id_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;
    logic        en_a, en_b, regce_a, regce_b;
    logic [3:0]  we_a, we_b;
    logic [8:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b, dout_a, dout_b;

    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];
    logic [31:0] d1_a, d2_a, d1_b;

    int checks = 0;
    int errors = 0;
    int hist [8];
    int exp_g;

    always #5 clk = ~clk;

    bram_port_arbiter #(.READ_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid_a),
        .rsp_id(rsp_id_a), .rsp_rdata(rsp_rdata_a), .bram_en(en_a), .bram_we(we_a),
        .bram_addr(addr_a), .bram_din(din_a), .bram_regce(regce_a), .bram_dout(dout_a)
    );

    bram_port_arbiter #(.READ_LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid_b),
        .rsp_id(rsp_id_b), .rsp_rdata(rsp_rdata_b), .bram_en(en_b), .bram_we(we_b),
        .bram_addr(addr_b), .bram_din(din_b), .bram_regce(regce_b), .bram_dout(dout_b)
    );

    // Byte-write RAMs: array latch on en, optional output register on regce.
    always @(posedge clk) begin
        if (en_a) begin
            for (int l = 0; l < 4; l++) if (we_a[l]) mem_a[addr_a][l*8 +: 8] <= din_a[l*8 +: 8];
            d1_a <= mem_a[addr_a];
        end
        if (regce_a) d2_a <= d1_a;
        if (en_b) begin
            for (int l = 0; l < 4; l++) if (we_b[l]) mem_b[addr_b][l*8 +: 8] <= din_b[l*8 +: 8];
            d1_b <= mem_b[addr_b];
        end
    end

    assign dout_a = d2_a;
    assign dout_b = d1_b;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cmd(input int i, input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] b);
        req_we[i]             = w;
        req_addr[i*9 +: 9]    = a;
        req_wdata[i*32 +: 32] = d;
        req_be[i*4 +: 4]      = b;
    endtask

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        d1_a = '0;
        d2_a = '0;
        d1_b = '0;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("rst_ready_a", ready_a, 0);
        check("rst_ready_b", ready_b, 0);
        check("rst_en", en_a, 0);
        check("rst_we", we_a, 0);
        check("rst_regce_a", regce_a, 0);
        check("rst_regce_b", regce_b, 0);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rsp_id", rsp_id_a, 0);
        check("rst_rsp_rdata", rsp_rdata_a, 0);
        check("rst_rsp_valid_b", rsp_valid_b, 0);

        @(negedge clk);
        rst = 1'b0;
        cmd(2, 1'b1, 9'h10, 32'hAABBCCDD, 4'b0101);
        req_valid = 4'b0100;
        #1;
        check("wr_ready", ready_a, 4'b0100);
        check("wr_ready_b", ready_b, 4'b0100);
        check("wr_en", en_a, 1);
        check("wr_we", we_a, 4'b0101);
        check("wr_addr", addr_a, 9'h10);
        check("wr_din", din_a, 32'hAABBCCDD);

        @(negedge clk);
        cmd(2, 1'b0, 9'h10, 32'h0, 4'h0);
        #1;
        check("rd_ready", ready_a, 4'b0100);
        check("rd_en", en_a, 1);
        check("rd_we", we_a, 0);
        check("rd_regce_idle", regce_a, 0);

        @(negedge clk);
        req_valid = '0;
        #1;
        check("idle_en", en_a, 0);
        check("idle_addr", addr_a, 0);
        check("idle_din", din_a, 0);
        check("lat2_early", rsp_valid_a, 0);
        check("lat2_regce", regce_a, 1);
        check("lat1_valid", rsp_valid_b, 1);
        check("lat1_id", rsp_id_b, 2);
        check("lat1_rdata", rsp_rdata_b, 32'h00BB00DD);
        check("lat1_regce", regce_b, 1);

        @(negedge clk);
        #1;
        check("lat2_valid", rsp_valid_a, 1);
        check("lat2_id", rsp_id_a, 2);
        check("lat2_rdata", rsp_rdata_a, 32'h00BB00DD);
        check("lat1_pulse", rsp_valid_b, 0);
        check("lat1_gated", rsp_rdata_b, 0);
        check("lat1_regce_hold", regce_b, 1);

        @(negedge clk);
        cmd(1, 1'b1, 9'h10, 32'hFFFFFFFF, 4'h0);
        req_valid = 4'b0010;
        #1;
        check("lat2_pulse", rsp_valid_a, 0);
        check("be0_ready", ready_a, 4'b0010);
        check("be0_we", we_a, 0);
        check("be0_no_rsp", rsp_valid_b, 0);

        @(negedge clk);
        cmd(1, 1'b0, 9'h10, 32'h0, 4'h0);
        #1;
        check("rd1_ready", ready_a, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        check("be0_valid", rsp_valid_a, 1);
        check("be0_id", rsp_id_a, 1);
        check("be0_rdata", rsp_rdata_a, 32'h00BB00DD);

        @(negedge clk);
        cmd(0, 1'b0, 9'h10, 32'h0, 4'h0);
        req_valid = 4'b0001;
        #1;
        check("pre_rst_ready", ready_a, 4'b0001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready_a, 0);
        check("mid_rst_drop_b", rsp_valid_b, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        check("post_rst_a", rsp_valid_a, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("drop_a", rsp_valid_a, 0);
            check("drop_b", rsp_valid_b, 0);
        end

        for (int i = 0; i < 4; i++) cmd(i, 1'b0, 9'(i), 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 4'hF;
            #1;
`ifdef BRAM_ARB_RR_EN
            exp_g = k % 4;
`else
            exp_g = 0;
`endif
            hist[k] = exp_g;
            check("all_ready_a", ready_a, 64'(1) << exp_g);
            check("all_ready_b", ready_b, 64'(1) << exp_g);
            check("all_valid_a", rsp_valid_a, (k >= 2) ? 1 : 0);
            check("all_valid_b", rsp_valid_b, (k >= 1) ? 1 : 0);
            if (k >= 2) check("all_id_a", rsp_id_a, 64'(hist[k-2]));
            if (k >= 1) check("all_id_b", rsp_id_b, 64'(hist[k-1]));
        end

        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        check("solo0_ready", ready_a, 4'b0001);
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        check("solo3_ready", ready_a, 4'b1000);
        check("solo3_ready_b", ready_b, 4'b1000);
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("wrap_ready", ready_a, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one port of the byte-enable block RAM between `NUM_REQ` requesters. Each requester issues single-beat read or byte-masked write commands over a valid/ready handshake. The arbiter grants at most one command per cycle and drives the RAM port's `en`/`we`/`addr`/`din`/`regce`. It tracks read latency and returns read data tagged with the requester ID. It sits between client engines (DMA, CPU load/store, descriptor fetch) and one RAM port; the other RAM port is untouched.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `NB_COL`, 4: byte lanes per word
- `COL_WIDTH`, 8: bits per lane
- `ADDR_WIDTH`, 9: word address width
- `READ_LATENCY`, 2: RAM read latency; 1 means no output register, 2 means output register
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in NUM_REQ: command valid, one bit per requester
- `req_ready` out NUM_REQ: one-hot grant; a command transfers when valid && ready
- `req_we` in NUM_REQ: 1 = write, 0 = read
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice i
- `req_wdata` in NUM_REQ*NB_COL*COL_WIDTH: packed write data
- `req_be` in NUM_REQ*NB_COL: packed byte enables, write only
- `rsp_valid` out 1: read data valid, single-cycle pulse
- `rsp_id` out $clog2(NUM_REQ): requester that owns the response
- `rsp_rdata` out NB_COL*COL_WIDTH: read data
- `bram_en` out 1, `bram_we` out NB_COL, `bram_addr` out ADDR_WIDTH, `bram_din` out NB_COL*COL_WIDTH, `bram_regce` out 1: RAM port drive
- `bram_dout` in NB_COL*COL_WIDTH: RAM port read data

## Operation
- Grant is combinational from `req_valid` and the priority state. At most one `req_ready` bit is high, and only if that requester's valid bit is high.
- Granted command drives the RAM in the same cycle:
  - `bram_en=1`, `bram_addr` = the requester's address.
  - Write: `bram_we` = the requester's `req_be`, `bram_din` = the requester's `req_wdata`.
  - Read: `bram_we=0`.
- With no grant: `bram_en=0`, `bram_we=0`, and `bram_addr`/`bram_din` are 0.
- A write with `req_be=0` is accepted and has no effect. Writes produce no response.
- Read tracking is a shift pipeline of `READ_LATENCY` stages, each holding {valid, id}.
  - `rsp_valid`/`rsp_id` come from the last stage.
  - `rsp_rdata` = `bram_dout` passthrough, gated to 0 when `rsp_valid=0`.
  - `bram_regce` = stage-1 valid when `READ_LATENCY=2`, constant 1 when `READ_LATENCY=1`.
- Responses return in issue order and cannot be back-pressured.
- Requesters must hold `req_valid` and the command fields stable until ready. The arbiter does not check this.
- Read and write to the same address in consecutive cycles: the read returns the data written earlier. In the same cycle only one command can issue.

## Timing
- Read issued at cycle T produces `rsp_valid` at T+READ_LATENCY.
- Throughput is one command per cycle, reads and writes mixed freely.
- While `rst` is high:
  - `req_ready`, `bram_en`, `bram_we` and `bram_regce` are forced to 0.
  - Pipeline stages are cleared, so `rsp_valid=0`, `rsp_id=0`, `rsp_rdata=0`.
  - Priority pointer resets to 0.
- Reset mid-operation: in-flight reads are dropped and produce no response. The first grant after reset release follows pointer 0.
- If no requester is valid, the pointer holds its value.

## Configuration
- `BRAM_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at the pointer and wraps from NUM_REQ-1 to 0.
  - After each grant the pointer becomes (granted index + 1) mod NUM_REQ.
- Not defined: fixed priority, lowest index wins. No pointer register exists.

## Structure
- Package `bram_arb_pkg` holds:
  - Function `clog2_min1` (width of `rsp_id`, minimum 1).
  - Typedef `rd_track_t` for {valid, id}.
  - Constants `LAT_NOREG=1`, `LAT_REG=2`.
- Sub-module `bram_arb_pick`: combinational priority picker that takes the request vector and the start pointer and returns a one-hot grant and an encoded index. It is instantiated once; the round-robin pointer register lives in the parent.

## Test plan
- Requester 2 writes addr 0x10, data 0xAABBCCDD, be 4'b0101; then reads addr 0x10 after prior content 0 -> `rsp_valid` 2 cycles after the read grant, `rsp_id=2`, `rsp_rdata=0x00BB00DD`.
- All four requesters hold reads continuously, `BRAM_ARB_RR_EN` defined -> grants cycle 0,1,2,3,0,… with one grant per cycle and responses in the same order.
- Same stimulus without the macro -> requester 0 granted every cycle and requesters 1–3 never see ready.
- `READ_LATENCY=1` -> `rsp_valid` 1 cycle after the grant and `bram_regce` held at 1.
- Reads issued at T and T+1, `rst` pulsed at T+1 -> no `rsp_valid` at any later cycle, and the next grant goes to requester 0.
- Only requester 3 valid, pointer at 1 -> requester 3 granted immediately and the pointer becomes 0.
